// File: rtl/fs_accel_pkg.sv
// Shared constants and types for the feature-map window generator.
package fs_accel_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_TAPS = 9;
  localparam int unsigned MIN_DIM  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fs_accel_line_buf.sv
// One row of pixel storage: combinational read, synchronous write, addressed by column.
module fs_accel_line_buf #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/fs_accel_win_gen.sv
// 3x3 sliding-window generator over a raster pixel stream, two rows held in line buffers.
// Optional stride-2 mode is compiled in with FS_ACCEL_WIN_STRIDE2_EN.
module fs_accel_win_gen #(
  parameter int unsigned MAX_WIDTH = 32,
  parameter int unsigned DATA_W    = fs_accel_pkg::DATA_W,
  parameter int unsigned HW        = 16,
  localparam int unsigned CW       = $clog2(MAX_WIDTH + 1),
  localparam int unsigned AW       = $clog2(MAX_WIDTH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [CW-1:0]            cfg_width,
  input  logic [HW-1:0]            cfg_height,
`ifdef FS_ACCEL_WIN_STRIDE2_EN
  input  logic                     cfg_stride2,
`endif
  input  logic signed [DATA_W-1:0] in_pixel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] win_0,
  output logic signed [DATA_W-1:0] win_1,
  output logic signed [DATA_W-1:0] win_2,
  output logic signed [DATA_W-1:0] win_3,
  output logic signed [DATA_W-1:0] win_4,
  output logic signed [DATA_W-1:0] win_5,
  output logic signed [DATA_W-1:0] win_6,
  output logic signed [DATA_W-1:0] win_7,
  output logic signed [DATA_W-1:0] win_8,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);
  import fs_accel_pkg::*;

  state_t state_q, state_d;

  logic [CW-1:0]            width_q;
  logic [HW-1:0]            height_q;
  logic [AW-1:0]            col_q;
  logic [HW-1:0]            row_q;
  logic                     last_q;
  logic                     out_valid_q;
  logic                     cfg_err_q;
  logic signed [DATA_W-1:0] win_q [NUM_TAPS];
  logic [DATA_W-1:0]        lb0_rd, lb1_rd;
  logic                     accept, cfg_ok, start_ok, col_last, row_last, emit;

  assign cfg_ok   = (cfg_width >= CW'(MIN_DIM)) && (cfg_width <= CW'(MAX_WIDTH)) &&
                    (cfg_height >= HW'(MIN_DIM));
  assign start_ok = (state_q == IDLE) && start && cfg_ok;
  assign accept   = in_valid && in_ready;
  assign col_last = (CW'(col_q) == width_q - CW'(1));
  assign row_last = (row_q == height_q - HW'(1));

`ifdef FS_ACCEL_WIN_STRIDE2_EN
  logic stride2_q;

  always_ff @(posedge clk) begin
    if (!resetn)       stride2_q <= 1'b0;
    else if (start_ok) stride2_q <= cfg_stride2;
  end

  // (r-2) and (c-2) even is the same as r and c even
  assign emit = (row_q >= HW'(2)) && (col_q >= AW'(2)) &&
                (!stride2_q || (!row_q[0] && !col_q[0]));
`else
  assign emit = (row_q >= HW'(2)) && (col_q >= AW'(2));
`endif

  fs_accel_line_buf #(
    .DEPTH  (MAX_WIDTH),
    .DATA_W (DATA_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  fs_accel_line_buf #(
    .DEPTH  (MAX_WIDTH),
    .DATA_W (DATA_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (in_pixel),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      // Finish once the last pixel is in and no window is left waiting
      RUN:     if (last_q && (!out_valid_q || out_ready)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == RUN) && (!out_valid_q || out_ready) && !last_q;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      width_q     <= '0;
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) win_q[i] <= '0;
    end else begin
      cfg_err_q <= (state_q == IDLE) && start && !cfg_ok;
      if (start_ok) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        col_q    <= '0;
        row_q    <= '0;
        last_q   <= 1'b0;
      end
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win_q[3*i]   <= win_q[3*i+1];
          win_q[3*i+1] <= win_q[3*i+2];
        end
        win_q[2] <= lb0_rd;
        win_q[5] <= lb1_rd;
        win_q[8] <= in_pixel;
        if (col_last) begin
          col_q <= '0;
          if (row_last) begin
            row_q  <= '0;
            last_q <= 1'b1;
          end else begin
            row_q <= row_q + HW'(1);
          end
        end else begin
          col_q <= col_q + AW'(1);
        end
      end
      if (accept && emit) out_valid_q <= 1'b1;
      else if (out_ready) out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;
  assign win_0 = win_q[0];
  assign win_1 = win_q[1];
  assign win_2 = win_q[2];
  assign win_3 = win_q[3];
  assign win_4 = win_q[4];
  assign win_5 = win_q[5];
  assign win_6 = win_q[6];
  assign win_7 = win_q[7];
  assign win_8 = win_q[8];

endmodule

// File: doc/fs_accel_win_gen.md
Name: fs_accel_win_gen

Overview:
- Sliding-window generator feeding the 3x3 processing unit; the producer end of the PU's window/enb interface.
- Accepts a raster-order stream of signed 8-bit feature-map pixels and buffers two previous rows in line buffers.
- Emits one 3x3 window per valid output position (stride 1, no padding), row-major: win_0 = top-left … win_8 = bottom-right.
- out_valid drives the PU enb; out_ready is tied to 1 when driving the PU directly.

Parameters:
- MAX_WIDTH, 32, maximum feature-map width in pixels (line buffer depth).
- DATA_W, 8, pixel width in bits (signed).
- HW, 16, width of the cfg_height port and the row counter.

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; latches cfg_* and begins a frame (IDLE only)
cfg_width  in  $clog2(MAX_WIDTH+1)  frame width W, legal 3..MAX_WIDTH
cfg_height  in  HW  frame height H, legal >=3
in_pixel  in  DATA_W  signed input pixel
in_valid  in  1  pixel valid
in_ready  out  1  block accepts pixel
win_0..win_8  out  DATA_W each  signed window taps, row-major
out_valid  out  1  window valid (PU enb)
out_ready  in  1  downstream accepts window
busy  out  1  frame in progress
done  out  1  one-cycle pulse, frame complete
cfg_err  out  1  one-cycle pulse, start with illegal config

Behaviour:
- Reset values: in_ready=0, out_valid=0, win_*=0, busy=0, done=0, cfg_err=0, state=IDLE, col=row=0. Line buffer contents are not reset.
- States and transitions:
  - IDLE -> RUN: on start with legal cfg.
  - IDLE, start with illegal cfg (W<3, W>MAX_WIDTH, or H<3): cfg_err=1 next cycle; stays IDLE.
  - start outside IDLE is ignored.
  - RUN -> DONE: when the last window is handed off.
  - DONE -> IDLE: after one cycle with done=1.
- busy=1 in RUN and DONE.
- in_ready = (state==RUN) && (!out_valid || out_ready) && !last_pixel_taken.
- Accept event: in_valid && in_ready, with pixel p at (row r, col c).
  - Read lb0[c] (row r-2) and lb1[c] (row r-1); line buffer read is combinational.
  - Window shifts left one column; the new right column is {lb0[c], lb1[c], p} top to bottom.
  - Write lb0[c] <= lb1[c] and lb1[c] <= p.
  - col increments; it wraps to 0 at W-1 and row increments.
- Output:
  - If the accept has r>=2 and c>=2, out_valid=1 the next cycle with the new window on win_* (latency 1).
  - Otherwise, if out_ready was seen this cycle, out_valid=0.
  - Accept and window handoff may occur in the same cycle.
- Hold: while out_valid && !out_ready, win_* and out_valid stay stable and in_ready=0.
- Frame length: (H-2)*(W-2) windows per frame. Pixels at c<2 or r<2 only prime the buffers.
- Last pixel: after pixel (H-1, W-1) is accepted, in_ready=0. Enter DONE on the cycle its window is taken (out_valid && out_ready). done=1 on the following cycle.
- Arithmetic: pixels pass through unmodified; no offset or sign change. Counters never exceed W-1 and H-1.
- Reset mid-frame: returns to IDLE, any pending window is dropped, and the next frame restarts cleanly.

Optional Feature:
- Macro: FS_ACCEL_WIN_STRIDE2_EN.
- Defined:
  - Adds input port cfg_stride2, latched on start.
  - When cfg_stride2=1, a window is emitted only when (r-2) and (c-2) are both even.
  - Frame length: floor((H-1)/2)*floor((W-1)/2) windows.
  - Pixel acceptance is unchanged.
- Undefined: no cfg_stride2 port; stride is fixed at 1.

Decomposition:
- Package fs_accel_pkg holds:
  - DATA_W and the window tap count (9).
  - The state enum {IDLE, RUN, DONE}.
  - The minimum legal dimension (3).
- Sub-module fs_accel_line_buf: MAX_WIDTH x DATA_W array with combinational read and synchronous write, addressed by col. Instantiated twice (lb0, lb1).

Test Plan:
- 4x4 frame, pixels 0..15, out_ready=1 -> 4 windows.
  - First: {0,1,2,4,5,6,8,9,10}.
  - Last: {5,6,7,9,10,11,13,14,15}.
  - done one cycle after the last handoff.
- Same 4x4 frame, out_ready toggling 1010… and random in_valid gaps -> identical 4 windows; win_* stable while stalled; no pixel lost.
- W=MAX_WIDTH=32, H=3, pixels -128..-97 then continuing values -> 30 windows; signed values pass through bit-exact.
- start with W=2, then W=33 -> cfg_err pulse each time; busy stays 0; in_ready stays 0.
- resetn low for one cycle after the 7th pixel of a 5x5 frame, then a new 4x4 frame 0..15 -> only the 4x4 windows appear, with the correct first window.
- With FS_ACCEL_WIN_STRIDE2_EN, 5x5 frame 0..24, cfg_stride2=1 -> 4 windows, starting at top-left pixels 0, 2, 10, 12.
